// File: rtl/sprite_collision_ctrl.sv
// ============================================================================
// Module   : sprite_collision_ctrl
// Purpose  : Per-frame player/terrain overlap counting plus the game-state FSM
//            (lives, hit recovery, game over). Optional SPRITE_COLLISION_INVULN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sprite_collision_ctrl #(
    parameter int NUM_TERRAIN   = 4,
    parameter int HIT_THRESHOLD = 8,
    parameter int LIVES_INIT    = 3,
    parameter int FLASH_FRAMES  = 60,
    parameter int CNT_W         = 12
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_v_sync,
    input  logic                   i_player_hit,
    input  logic [NUM_TERRAIN-1:0] i_terrain_hit,
    input  logic                   i_start,
    output logic                   o_active,
    output logic [1:0]             o_state,
    output logic [3:0]             o_lives,
    output logic                   o_collision_pulse,
    output logic                   o_flash,
    output logic [CNT_W-1:0]       o_overlap_cnt
);

    localparam int c_THR   = (HIT_THRESHOLD < 1) ? 1 : HIT_THRESHOLD;
    localparam int c_FLASH = (FLASH_FRAMES < 1) ? 1 : FLASH_FRAMES;
    localparam int c_FL_W  = ($clog2(c_FLASH + 1) < 4) ? 4 : $clog2(c_FLASH + 1);
    localparam logic [3:0]        c_LIVES    = 4'(LIVES_INIT);
    localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;
    localparam logic [c_FL_W-1:0] c_FL_INIT  = c_FL_W'(c_FLASH);
    localparam logic [c_FL_W-1:0] c_FL_ONE   = c_FL_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t              r_state;
    logic [3:0]          r_lives;
    logic                r_active;
    logic                r_pulse;
    logic                r_flash;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_acc;
    logic [c_FL_W-1:0]   r_flash_cnt;
    logic                r_vs_q;
    logic                r_start_q;

    logic                w_frame_tick;
    logic                w_start_edge;
    logic                w_overlap;
    logic [CNT_W:0]      w_sum;
    logic [CNT_W-1:0]    w_total;
    logic                w_hit;
    logic [c_FL_W-1:0]   w_flash_dec;

    assign w_frame_tick = i_v_sync & ~r_vs_q;
    assign w_start_edge = i_start & ~r_start_q;
    // Gating by PLAY keeps the frame total at zero in every other state.
    assign w_overlap    = i_player_hit & (|i_terrain_hit) & (r_state == S_PLAY);
    assign w_sum        = {1'b0, r_acc} + {{CNT_W{1'b0}}, w_overlap};
    assign w_total      = w_sum[CNT_W] ? c_CNT_MAX : w_sum[CNT_W-1:0];
    assign w_hit        = (32'(w_total) >= 32'(c_THR));
    assign w_flash_dec  = r_flash_cnt - c_FL_ONE;

`ifndef SPRITE_COLLISION_INVULN_EN
    logic [3:0] w_lives_dec;
    assign w_lives_dec = r_lives - 4'd1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_lives     <= c_LIVES;
            r_active    <= 1'b0;
            r_pulse     <= 1'b0;
            r_flash     <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_flash_cnt <= '0;
            r_vs_q      <= 1'b0;
            r_start_q   <= 1'b1;
        end else begin
            r_vs_q    <= i_v_sync;
            r_start_q <= i_start;
            r_pulse   <= 1'b0;
            if (w_frame_tick) begin
                r_cnt <= w_total;
            end
            case (r_state)
                S_IDLE: begin
                    r_lives <= c_LIVES;
                    r_acc   <= '0;
                    if (w_start_edge) begin
                        r_state  <= S_PLAY;
                        r_active <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (w_frame_tick) begin
                        r_acc <= '0;
                        if (w_hit) begin
                            r_pulse <= 1'b1;
`ifndef SPRITE_COLLISION_INVULN_EN
                            r_active <= 1'b0;
                            if (w_lives_dec == 4'd0) begin
                                r_state <= S_OVER;
                                r_lives <= 4'd0;
                            end else begin
                                r_state     <= S_HIT;
                                r_lives     <= w_lives_dec;
                                r_flash_cnt <= c_FL_INIT;
                                r_flash     <= c_FL_INIT[3];
                            end
`endif
                        end
                    end else begin
                        r_acc <= w_total;
                    end
                end
                S_HIT: begin
                    r_acc <= '0;
                    if (w_frame_tick) begin
                        r_flash_cnt <= w_flash_dec;
                        if (r_flash_cnt == c_FL_ONE) begin
                            r_state  <= S_PLAY;
                            r_active <= 1'b1;
                            r_flash  <= 1'b0;
                        end else begin
                            r_flash  <= w_flash_dec[3];
                        end
                    end
                end
                S_OVER: begin
                    r_acc   <= '0;
                    r_lives <= 4'd0;
                    if (w_start_edge) begin
                        r_state <= S_IDLE;
                        r_lives <= c_LIVES;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign o_active          = r_active;
    assign o_state           = r_state;
    assign o_lives           = r_lives;
    assign o_collision_pulse = r_pulse;
    assign o_flash           = r_flash;
    assign o_overlap_cnt     = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sprite_collision_ctrl.sv
// Bench for sprite_collision_ctrl: game-level reference model checked every cycle,
// plus directed frames with hand-computed literal expectations.
`default_nettype none
`timescale 1ns/1ps

module tb_sprite_collision_ctrl;

    localparam int LI   = 3;
    localparam int THR  = 8;
    localparam int FF   = 60;
    localparam int CMAX = 4095;
    localparam int ST_IDLE = 0, ST_PLAY = 1, ST_HIT = 2, ST_OVER = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        vs    = 1'b0;
    logic        ph    = 1'b0;
    logic        st    = 1'b0;
    logic [3:0]  th    = 4'd0;

    logic        o_active;
    logic [1:0]  o_state;
    logic [3:0]  o_lives;
    logic        o_collision_pulse;
    logic        o_flash;
    logic [11:0] o_overlap_cnt;

    sprite_collision_ctrl #(
        .NUM_TERRAIN(4), .HIT_THRESHOLD(THR), .LIVES_INIT(LI),
        .FLASH_FRAMES(FF), .CNT_W(12)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_v_sync(vs), .i_player_hit(ph),
        .i_terrain_hit(th), .i_start(st), .o_active(o_active), .o_state(o_state),
        .o_lives(o_lives), .o_collision_pulse(o_collision_pulse), .o_flash(o_flash),
        .o_overlap_cnt(o_overlap_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Game-level reference model
    int m_state = ST_IDLE, m_lives = LI, m_acc = 0, m_cnt = 0, m_flash = 0;
    int m_pulse = 0, m_pvs = 0, m_pst = 1;

    task automatic model_reset();
        m_state = ST_IDLE; m_lives = LI; m_acc = 0; m_cnt = 0; m_flash = 0;
        m_pulse = 0; m_pvs = 0; m_pst = 1;
    endtask

    task automatic model_step();
        int ft, se, ov, total;
        ft = (vs && !m_pvs) ? 1 : 0;
        se = (st && !m_pst) ? 1 : 0;
        ov = (ph && (th != 0)) ? 1 : 0;
        m_pvs = vs; m_pst = st; m_pulse = 0;
        total = (m_acc + ov > CMAX) ? CMAX : m_acc + ov;
        if (ft) m_cnt = (m_state == ST_PLAY) ? total : 0;
        case (m_state)
            ST_IDLE: if (se) m_state = ST_PLAY;
            ST_PLAY: begin
                if (ft) begin
                    m_acc = 0;
                    if (total >= THR) begin
                        m_pulse = 1;
`ifndef SPRITE_COLLISION_INVULN_EN
                        m_lives = m_lives - 1;
                        if (m_lives == 0) m_state = ST_OVER;
                        else begin m_state = ST_HIT; m_flash = FF; end
`endif
                    end
                end else m_acc = total;
            end
            ST_HIT: if (ft) begin
                m_flash = m_flash - 1;
                if (m_flash == 0) m_state = ST_PLAY;
            end
            default: if (se) begin m_state = ST_IDLE; m_lives = LI; end
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
        #1;
        check("cyc_state",  o_state, m_state);
        check("cyc_lives",  o_lives, m_lives);
        check("cyc_active", o_active, (m_state == ST_PLAY) ? 1 : 0);
        check("cyc_pulse",  o_collision_pulse, m_pulse);
        check("cyc_flash",  o_flash, (m_state == ST_HIT) ? ((m_flash >> 3) & 1) : 0);
        check("cyc_cnt",    o_overlap_cnt, m_cnt);
    end

    task automatic drive(input logic v, input logic p, input logic [3:0] t);
        @(negedge clk);
        vs = v; ph = p; th = t;
    endtask

    // Overlap cycles, a gap, then the v_sync rise (optionally carrying an overlap).
    task automatic frame(input int nov, input bit tov, input logic p, input logic [3:0] t);
        for (int k = 0; k < nov; k++) drive(1'b0, p, t);
        drive(1'b0, 1'b0, 4'd0);
        drive(1'b1, tov ? p : 1'b0, tov ? t : 4'd0);
        drive(1'b1, 1'b0, 4'd0);
    endtask

    initial begin
        st = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("lit_held_start_state", o_state, 0);
        check("lit_held_start_lives", o_lives, 3);
        st = 1'b0;
        @(negedge clk);
        st = 1'b1;
        @(negedge clk);
        check("lit_start_state", o_state, 1);
        check("lit_start_active", o_active, 1);
        st = 1'b0;
`ifdef SPRITE_COLLISION_INVULN_EN
        begin
            int np;
            np = 0;
            for (int i = 0; i < 5; i++) begin
                frame(8, 1'b0, 1'b1, 4'b0001);
                if (o_collision_pulse) np++;
            end
            check("lit_inv_pulses", np, 5);
            check("lit_inv_lives", o_lives, 3);
            check("lit_inv_state", o_state, 1);
        end
`else
        frame(7, 1'b0, 1'b1, 4'b0001);
        check("lit_7_cnt", o_overlap_cnt, 7);
        check("lit_7_pulse", o_collision_pulse, 0);
        check("lit_7_state", o_state, 1);
        frame(8, 1'b0, 1'b1, 4'b0011);
        check("lit_8_cnt", o_overlap_cnt, 8);
        check("lit_8_pulse", o_collision_pulse, 1);
        check("lit_8_lives", o_lives, 2);
        check("lit_8_state", o_state, 2);
        check("lit_8_active", o_active, 0);
        @(negedge clk);
        check("lit_pulse_one_cycle", o_collision_pulse, 0);

        for (int i = 0; i < 60; i++) begin
            frame(3, 1'b1, 1'b1, 4'hF);
            if (i == 0)  begin check("lit_hit_flash0", o_flash, 1); check("lit_hit_cnt", o_overlap_cnt, 0); end
            if (i == 4)  check("lit_hit_flash4", o_flash, 0);
            if (i == 12) check("lit_hit_flash12", o_flash, 1);
            if (i == 58) check("lit_hit_f59_state", o_state, 2);
            if (i == 59) begin check("lit_hit_f60_state", o_state, 1); check("lit_hit_f60_flash", o_flash, 0); end
        end

        st = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lit_start_ignored_play", o_state, 1);
        st = 1'b0;
        frame(20, 1'b1, 1'b1, 4'd0);
        check("lit_player_only", o_overlap_cnt, 0);
        frame(20, 1'b1, 1'b0, 4'hF);
        check("lit_terrain_only", o_overlap_cnt, 0);
        frame(7, 1'b1, 1'b1, 4'b1000);
        check("lit_tick_ovl_cnt", o_overlap_cnt, 8);
        check("lit_tick_ovl_pulse", o_collision_pulse, 1);
        check("lit_tick_ovl_lives", o_lives, 1);

        for (int i = 0; i < 60; i++) frame(0, 1'b0, 1'b0, 4'd0);
        check("lit_recover_state", o_state, 1);
        frame(4100, 1'b0, 1'b1, 4'b0100);
        check("lit_sat_cnt", o_overlap_cnt, 4095);
        check("lit_over_state", o_state, 3);
        check("lit_over_lives", o_lives, 0);

        st = 1'b1;
        @(negedge clk);
        check("lit_over_to_idle", o_state, 0);
        check("lit_idle_lives", o_lives, 3);
        st = 1'b0;
        @(negedge clk);
        check("lit_idle_stays", o_state, 0);
        st = 1'b1;
        @(negedge clk);
        check("lit_second_start", o_state, 1);
        st = 1'b0;

        frame(8, 1'b0, 1'b1, 4'b0001);
        check("lit_pre_rst_state", o_state, 2);
        check("lit_pre_rst_pulse", o_collision_pulse, 1);
        drive(1'b0, 1'b1, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        check("lit_rst_state", o_state, 0);
        check("lit_rst_lives", o_lives, 3);
        check("lit_rst_pulse", o_collision_pulse, 0);
        check("lit_rst_flash", o_flash, 0);
        @(negedge clk);
        rst_n = 1'b1;
`endif
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sprite_collision_ctrl.md
Name: sprite_collision_ctrl

Overview:
- Downstream consumer of the per-pixel `o_sprite_hit` flags from the player sprite and the terrain sprites.
- Counts player/terrain overlap pixels each frame and decides at frame end whether a collision occurred.
- Runs the game-state FSM: lives, hit recovery and game over.
- Its `o_active` output drives the `ACTIVE` input of the terrain sprites, closing the loop.

Parameters:
- NUM_TERRAIN, 4, number of terrain `sprite_hit` inputs.
- HIT_THRESHOLD, 8, minimum overlap pixels in one frame that count as a collision; a value of 0 is treated as 1.
- LIVES_INIT, 3, lives at start of game; range 1..15.
- FLASH_FRAMES, 60, frames spent in the HIT recovery state.
- CNT_W, 12, width of the overlap pixel counter.

Ports:
- i_clk  in  1  pixel clock; same clock as the timing generator driving i_x/i_y/i_v_sync.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_v_sync  in  1  vertical sync level; the same net fed to the sprite blocks.
- i_player_hit  in  1  player sprite `o_sprite_hit` (non-transparent player pixel).
- i_terrain_hit  in  NUM_TERRAIN  terrain sprite `o_sprite_hit` flags.
- i_start  in  1  start/restart button level, already debounced, synchronous to i_clk.
- o_active  out  1  to terrain `ACTIVE`; high only in PLAY.
- o_state  out  2  IDLE=0, PLAY=1, HIT=2, OVER=3.
- o_lives  out  4  remaining lives.
- o_collision_pulse  out  1  one-cycle pulse when a collision is registered.
- o_flash  out  1  player blink enable; high in HIT when flash_cnt[3]=1.
- o_overlap_cnt  out  CNT_W  overlap count of the last completed frame.

Behaviour:
- Reset (asynchronous, i_rst_n=0), applied immediately, also mid-frame or mid-state:
  - state=IDLE, o_lives=LIVES_INIT; all other outputs 0.
  - Accumulator=0, flash_cnt=0, vs_q=0.
  - start_q=1, so a button held through reset does not start a game.
- Edge detection, registered:
  - frame_tick = i_v_sync & ~vs_q.
  - start_edge = i_start & ~start_q.
  - Both are combinational from the current inputs and the previous-cycle registers; an event acts on the clock edge of the cycle in which it is detected.
- Overlap counting:
  - overlap = i_player_hit & (|i_terrain_hit).
  - Accumulated only in PLAY; saturates at 2^CNT_W-1 with no wrap.
  - On a frame_tick cycle, that cycle's overlap is included in the closing frame: total = acc + overlap, saturated.
  - On that same edge: o_overlap_cnt <= total and acc <= 0.
  - Outside PLAY, acc is held at 0; o_overlap_cnt is updated on every frame_tick (it reads 0 outside PLAY).
- FSM (all transitions take effect on the clock edge; outputs are registered):
  - IDLE: o_active=0; o_lives held at LIVES_INIT.
    - start_edge -> PLAY.
    - If frame_tick and start_edge coincide, start wins and acc starts from 0.
  - PLAY: o_active=1.
    - On frame_tick with total >= HIT_THRESHOLD: o_collision_pulse=1 for exactly one cycle and o_lives decrements.
    - If the new o_lives = 0 -> OVER; otherwise -> HIT with flash_cnt=FLASH_FRAMES.
    - start_edge is ignored in PLAY.
  - HIT: o_active=0 (terrain frozen).
    - flash_cnt decrements on each frame_tick.
    - On the frame_tick where flash_cnt goes from 1 to 0 -> PLAY; o_flash=0 on entry to PLAY.
  - OVER: o_active=0, o_lives=0.
    - start_edge -> IDLE with o_lives=LIVES_INIT.
    - Re-entering PLAY requires a second start edge.
- o_collision_pulse is 0 in every cycle other than the registering cycle.
- At most one collision is registered per frame.
- o_lives never underflows.

Optional Feature:
- Macro: SPRITE_COLLISION_INVULN_EN.
- Defined:
  - Collisions still raise o_collision_pulse and update o_overlap_cnt.
  - o_lives never decrements and the FSM stays in PLAY (no HIT or OVER entry).
  - Intended for level debugging.
- Undefined: full behaviour as above.

Test Plan:
- Hold i_start=1 through reset release -> o_state=0 and o_lives=3 persist. Drop i_start, then raise it -> o_state=1 and o_active=1 on the next edge.
- In PLAY, 7 overlap cycles then an i_v_sync rise -> o_overlap_cnt=7, no pulse, state stays 1. Next frame, 8 overlaps -> o_collision_pulse high for 1 cycle, o_lives=2, o_state=2, o_active=0.
- 7 overlaps plus 1 overlap on the exact v_sync rising cycle -> total=8, collision registered. Player-only or terrain-only hits -> no count.
- In HIT with FLASH_FRAMES=60: overlaps are injected -> o_overlap_cnt=0. After the 60th v_sync rise -> o_state=1. o_flash toggles every 8 frames.
- Three collisions from LIVES_INIT=3 -> o_lives=0, o_state=3. Start edge -> o_state=0, o_lives=3. Second start edge -> o_state=1.
- CNT_W=4 with 20 overlaps in one frame -> o_overlap_cnt=15.
- Assert i_rst_n=0 in HIT mid-frame -> immediately o_state=0, o_lives=3, all pulses 0.
- With SPRITE_COLLISION_INVULN_EN defined -> 5 collisions give 5 pulses, o_lives=3, o_state=1.
